// File: rtl/uart_tx_sb_ctrl.sv
// Bus-attached UART transmitter: 8N1 framing, programmable bit divider and a
// small circular TX FIFO, all behind a four-register single-cycle slave port.
module uart_tx_sb_ctrl #(
    parameter int clk_mhz    = 50,
    parameter int baud_rate  = 115200,
    parameter int fifo_depth = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        write_enable_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] write_data_i,
    output logic [31:0] read_data_o,
    output logic        ready_o,
    output logic        tx_o
);

    localparam int PW = $clog2(fifo_depth);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(fifo_depth);
    localparam logic [15:0]   DIV_RST = 16'(clk_mhz * 1000000 / baud_rate - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          tx_q, tx_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    idx_q, idx_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [15:0]   baud_div_q, baud_div_d;
    logic          enable_q, enable_d;
    logic          overflow_q, overflow_d;
    logic [31:0]   read_data_q, read_data_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    mem_q [fifo_depth];

    logic [23:0] offset_s;
    logic        wr_s, rd_s;
    logic        wr_data_s, wr_status_s, wr_baud_s, wr_ctrl_s;
    logic        flush_s, full_s, empty_s, busy_s;
    logic        push_ok_s, ovf_set_s, pop_s, bit_end_s;
    logic [31:0] rd_mux_s;
    logic        unused_ok_s;

    assign offset_s    = addr_i[23:0];
    assign wr_s        = req_i & write_enable_i;
    assign rd_s        = req_i & ~write_enable_i;
    assign wr_data_s   = wr_s & (offset_s == 24'h000000);
    assign wr_status_s = wr_s & (offset_s == 24'h000004);
    assign wr_baud_s   = wr_s & (offset_s == 24'h000008);
    assign wr_ctrl_s   = wr_s & (offset_s == 24'h00000C);
    assign flush_s     = wr_ctrl_s & write_data_i[1];

    assign full_s    = (count_q == DEPTH_C);
    assign empty_s   = (count_q == {CW{1'b0}});
    assign busy_s    = (state_q != ST_IDLE);
    assign bit_end_s = (cnt_q == 16'd0);

    // A flush wins over a coincident push; full is judged before any pop.
    assign push_ok_s = wr_data_s & ~full_s & ~flush_s;
    assign ovf_set_s = wr_data_s & full_s & ~flush_s;

    assign ready_o     = 1'b1;
    assign tx_o        = tx_q;
    assign read_data_o = read_data_q;
    assign unused_ok_s = ^{addr_i[31:24], write_data_i[31:16]};

    // Register-file read mux and read-data hold.
    always_comb begin
        rd_mux_s = 32'h0000_0000;
        case (offset_s)
            24'h000004: rd_mux_s = {28'h0000000, overflow_q, empty_s, full_s, busy_s};
            24'h000008: rd_mux_s = {16'h0000, baud_div_q};
            24'h00000C: rd_mux_s = {31'h00000000, enable_q};
            default:    rd_mux_s = 32'h0000_0000;
        endcase
        if (rd_s) begin
            read_data_d = rd_mux_s;
        end else begin
            read_data_d = read_data_q;
        end
    end

    // Control register updates and sticky overflow.
    always_comb begin
        baud_div_d = baud_div_q;
        enable_d   = enable_q;
        overflow_d = overflow_q;
        if (wr_baud_s) begin
            baud_div_d = (write_data_i[15:0] == 16'h0000) ? 16'd1 : write_data_i[15:0];
        end else begin
            baud_div_d = baud_div_q;
        end
        if (wr_ctrl_s) begin
            enable_d = write_data_i[0];
        end else begin
            enable_d = enable_q;
        end
        if (ovf_set_s) begin
            overflow_d = 1'b1;
        end else if (wr_status_s) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // FIFO pointer and occupancy bookkeeping.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_s) begin
            wr_ptr_d = {PW{1'b0}};
            rd_ptr_d = {PW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_ok_s, pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Frame sequencer: tx_d is the line level for the state being entered.
    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        pop_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (enable_q && !empty_s) begin
                    pop_s   = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    cnt_d   = baud_div_q;
                    tx_d    = 1'b0;
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    cnt_d   = baud_div_q;
                    idx_d   = 3'd0;
                    tx_d    = shift_q[0];
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    cnt_d = baud_div_q;
                    if (idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_STOP: begin
                if (bit_end_s) begin
                    tx_d    = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= write_data_i[7:0];
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= ST_IDLE;
            tx_q        <= 1'b1;
            shift_q     <= 8'h00;
            idx_q       <= 3'd0;
            cnt_q       <= 16'd0;
            baud_div_q  <= DIV_RST;
            enable_q    <= 1'b1;
            overflow_q  <= 1'b0;
            read_data_q <= 32'h0000_0000;
            wr_ptr_q    <= {PW{1'b0}};
            rd_ptr_q    <= {PW{1'b0}};
            count_q     <= {CW{1'b0}};
        end else begin
            state_q     <= state_d;
            tx_q        <= tx_d;
            shift_q     <= shift_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            baud_div_q  <= baud_div_d;
            enable_q    <= enable_d;
            overflow_q  <= overflow_d;
            read_data_q <= read_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_sb_ctrl.sv
// Scoreboard bench for uart_tx_sb_ctrl: a queue-level register/FIFO model
// predicts read data and the serial waveform of every frame.
module tb_uart_tx_sb_ctrl;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        tx;

    int n_checks = 0;
    int n_pass   = 0;

    uart_tx_sb_ctrl dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .req_i          (req_i),
        .write_enable_i (we_i),
        .addr_i         (addr),
        .write_data_i   (wdata),
        .read_data_o    (rdata),
        .ready_o        (ready),
        .tx_o           (tx)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [7:0]  mdl_fifo[$];
    bit          mdl_ovf;
    bit          mdl_en;
    int          mdl_div;

    // Scoreboard queues
    logic [31:0] rd_exp_q[$];
    string       rd_name_q[$];
    bit          rd_pend = 1'b0;
    logic        exp_wave[$];
    bit          frame_ok;
    logic [7:0]  cur_byte;
    int          skip_n = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic void mdl_reset();
        mdl_fifo.delete();
        mdl_ovf = 1'b0;
        mdl_en  = 1'b1;
        mdl_div = 433;
    endfunction

    function automatic logic [31:0] mdl_read(input logic [23:0] off, input bit busy);
        case (off)
            24'h4:   return {28'h0, mdl_ovf, mdl_fifo.size() == 0, mdl_fifo.size() == DEPTH, busy};
            24'h8:   return 32'(mdl_div);
            24'hC:   return {31'h0, mdl_en};
            default: return 32'h0;
        endcase
    endfunction

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        case (a[23:0])
            24'h0: begin
                if (mdl_fifo.size() == DEPTH) mdl_ovf = 1'b1;
                else mdl_fifo.push_back(d[7:0]);
            end
            24'h4: mdl_ovf = 1'b0;
            24'h8: mdl_div = (d[15:0] == 16'h0) ? 1 : int'(d[15:0]);
            24'hC: begin
                mdl_en = d[0];
                if (d[1]) mdl_fifo.delete();
            end
            default: ;
        endcase
        req_i = 1'b1; we_i = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        req_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic bus_rd(input logic [31:0] a, input bit busy, input string name);
        rd_exp_q.push_back(mdl_read(a[23:0], busy));
        rd_name_q.push_back(name);
        req_i = 1'b1; we_i = 1'b0; addr = a; wdata = 32'h0;
        @(negedge clk);
        req_i = 1'b0;
    endtask

    task automatic wait_drain(input int max_cycles);
        bit done;
        done = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (mdl_fifo.size() == 0 && exp_wave.size() == 0 && skip_n == 0) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!done) begin
            n_checks++;
            $display("FAIL drain_timeout: %0d bytes still expected after %0d cycles", mdl_fifo.size(), max_cycles);
        end
        repeat (2) @(negedge clk);
    endtask

    // Read monitor: any completed read is compared with the next expectation.
    always @(posedge clk) rd_pend <= rst_i && req_i && !we_i;

    always @(negedge clk) begin
        if (rd_pend) begin
            if (rd_exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_read: got 0x%0h, expected no read", rdata);
            end else begin
                check(rd_name_q.pop_front(), rdata, rd_exp_q.pop_front());
            end
        end
    end

    // Line monitor: each start bit claims the model's head byte and the whole
    // expected waveform of that frame is checked sample by sample.
    always @(negedge clk) begin
        if (!rst_i) begin
            exp_wave.delete();
            skip_n = 0;
        end else if (skip_n > 0) begin
            skip_n--;
        end else if (exp_wave.size() > 0) begin
            logic e;
            e = exp_wave.pop_front();
            if (tx !== e && frame_ok) begin
                frame_ok = 1'b0;
                $display("FAIL frame_%02h: tx_o=%b, expected %b with %0d samples left", cur_byte, tx, e, exp_wave.size());
            end
            if (exp_wave.size() == 0) begin
                n_checks++;
                if (frame_ok) n_pass++;
            end
        end else if (tx === 1'b0) begin
            if (mdl_fifo.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_frame: tx_o=0, expected idle line 1");
                skip_n = 10 * (mdl_div + 1) - 1;
            end else begin
                cur_byte = mdl_fifo.pop_front();
                frame_ok = 1'b1;
                for (int k = 0; k < mdl_div; k++) exp_wave.push_back(1'b0);
                for (int b = 0; b < 8; b++)
                    for (int k = 0; k <= mdl_div; k++) exp_wave.push_back(cur_byte[b]);
                for (int k = 0; k <= mdl_div; k++) exp_wave.push_back(1'b1);
            end
        end
    end

    initial begin
        rst_i = 1'b0; req_i = 1'b0; we_i = 1'b0; addr = 32'h0; wdata = 32'h0;
        mdl_reset();
        repeat (3) @(negedge clk);
        check("reset_tx_o", {31'h0, tx}, 32'h1);
        check("reset_ready_o", {31'h0, ready}, 32'h1);
        check("reset_read_data", rdata, 32'h0);
        rst_i = 1'b1;
        @(negedge clk);
        bus_rd(32'h4, 1'b0, "status_after_reset");
        bus_rd(32'h8, 1'b0, "baud_after_reset");
        bus_rd(32'hC, 1'b0, "ctrl_after_reset");

        // Basic frame with busy sampled mid-frame
        bus_wr(32'h8, 32'd3);
        bus_wr(32'h0, 32'hA5);
        repeat (4) @(negedge clk);
        bus_rd(32'h4, 1'b1, "status_busy_early");
        repeat (12) @(negedge clk);
        bus_rd(32'h4, 1'b1, "status_busy_mid");
        repeat (16) @(negedge clk);
        bus_rd(32'h4, 1'b1, "status_busy_late");
        wait_drain(200);
        bus_rd(32'h4, 1'b0, "status_after_basic");

        // Back-to-back frames
        bus_wr(32'h8, 32'd1);
        bus_wr(32'h0, 32'h01);
        bus_wr(32'h0, 32'h02);
        bus_wr(32'h0, 32'h03);
        wait_drain(300);
        bus_rd(32'h4, 1'b0, "status_after_b2b");

        // Overflow with transmission held off
        bus_wr(32'hC, 32'h0);
        for (int i = 0; i < 9; i++) bus_wr(32'h0, 32'($urandom_range(0, 255)));
        bus_rd(32'h4, 1'b0, "status_overflow");
        bus_wr(32'h4, 32'h0);
        bus_rd(32'h4, 1'b0, "status_ovf_cleared");
        bus_wr(32'hC, 32'h1);
        wait_drain(600);
        bus_rd(32'h4, 1'b0, "status_after_overflow");

        // Flush during a frame
        bus_wr(32'h0, 32'h11);
        bus_wr(32'h0, 32'h22);
        bus_wr(32'h0, 32'h33);
        bus_wr(32'h0, 32'h44);
        repeat (3) @(negedge clk);
        bus_rd(32'h4, 1'b1, "status_before_flush");
        bus_wr(32'hC, 32'h3);
        wait_drain(200);
        bus_rd(32'h4, 1'b0, "status_after_flush");
        bus_rd(32'hC, 1'b0, "ctrl_after_flush");

        // Reset in the middle of the data bits
        bus_wr(32'h8, 32'd3);
        bus_wr(32'h0, 32'h80);
        repeat (12) @(negedge clk);
        check("pre_reset_tx_low", {31'h0, tx}, 32'h0);
        rst_i = 1'b0;
        mdl_reset();
        @(posedge clk);
        #1;
        check("mid_frame_reset_tx_o", {31'h0, tx}, 32'h1);
        check("mid_frame_reset_ready", {31'h0, ready}, 32'h1);
        @(negedge clk);
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        bus_rd(32'h4, 1'b0, "status_after_mid_reset");
        bus_rd(32'h8, 1'b0, "baud_after_mid_reset");
        repeat (5) @(negedge clk);
        check("idle_after_mid_reset", {31'h0, tx}, 32'h1);

        // Divider and address decode
        bus_wr(32'h8, 32'h0);
        bus_rd(32'h8, 1'b0, "baud_zero_stored_as_one");
        bus_rd(32'h10, 1'b0, "unmapped_read");
        bus_wr(32'h0300_0008, 32'h0007);
        bus_rd(32'h8, 1'b0, "baud_upper_addr_ignored");
        bus_wr(32'h10, 32'hFFFF);
        bus_rd(32'h8, 1'b0, "unmapped_write_ignored");
        bus_rd(32'h0, 1'b0, "data_reads_zero");

        // Randomised frames at assorted dividers
        for (int it = 0; it < 4; it++) begin
            int n;
            bus_wr(32'h8, 32'($urandom_range(0, 3)));
            n = $urandom_range(1, 5);
            for (int j = 0; j < n; j++) bus_wr(32'h0, 32'($urandom_range(0, 255)));
            wait_drain(1000);
            bus_rd(32'h4, 1'b0, "status_after_random");
        end

        repeat (3) @(negedge clk);
        if (rd_exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL reads_outstanding: %0d reads never completed, expected 0", rd_exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
